// File: rtl/light_pkg.sv
// Shared encodings for the traffic-light safety monitor: lamp codes, monitor
// states and fault-cause codes.
package light_pkg;

  localparam logic [2:0] DARK   = 3'b000;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  typedef enum logic [1:0] {
    ST_MON     = 2'd0,
    ST_FLASH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ONEHOT    = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_G2R       = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;
  localparam logic [2:0] FC_BAD_SEQ   = 3'd5;

  function automatic logic is_one_hot(input logic [2:0] lamp);
    return (lamp == GREEN) || (lamp == YELLOW) || (lamp == RED);
  endfunction

endpackage

// File: rtl/approach_tracker.sv
// Per-approach history: previous request, consecutive-yellow run length, and
// the local check flags {bad_seq, short_yel, green_to_red, not_one_hot}.
module approach_tracker
  import light_pkg::*;
#(
  parameter int MIN_YEL = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] lamp,
  input  logic       suppress,
  output logic [3:0] flags
);

  localparam int CW = $clog2(MIN_YEL + 1);

  logic [2:0]    prev_r;
  logic [CW-1:0] yel_cnt_r;

  // History follows the raw request every cycle, whatever the monitor state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r    <= RED;
      yel_cnt_r <= {CW{1'b0}};
    end else begin
      prev_r <= lamp;
      if (lamp != YELLOW) begin
        yel_cnt_r <= {CW{1'b0}};
      end else if (yel_cnt_r == CW'(MIN_YEL)) begin
        yel_cnt_r <= yel_cnt_r;
      end else begin
        yel_cnt_r <= yel_cnt_r + CW'(1);
      end
    end
  end

  // Local checks; transition checks are masked right after a recovery
  always_comb begin
    flags    = 4'b0000;
    flags[0] = !is_one_hot(lamp);
    if (suppress) begin
      flags[3:1] = 3'b000;
    end else begin
      flags[1] = (prev_r == GREEN) && (lamp == RED);
      flags[2] = (prev_r == YELLOW) && (lamp == RED) && (yel_cnt_r < CW'(MIN_YEL));
      flags[3] = ((prev_r == RED) && (lamp == YELLOW)) ||
                 ((prev_r == YELLOW) && (lamp == GREEN));
    end
  end

endmodule

// File: rtl/light_safety_monitor.sv
// Safety monitor between a traffic controller and the lamp drivers: passes
// safe requests through, otherwise forces a red flash until acknowledged.
module light_safety_monitor
  import light_pkg::*;
#(
  parameter int MIN_YEL    = 3,
  parameter int FLASH_HALF = 4,
  parameter int ALLRED     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_M1,
  input  logic [2:0] in_M2,
  input  logic [2:0] in_MT,
  input  logic [2:0] in_S,
  input  logic       clr_fault,
  output logic [2:0] out_M1,
  output logic [2:0] out_M2,
  output logic [2:0] out_MT,
  output logic [2:0] out_S,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int FCW = $clog2(2 * FLASH_HALF);
  localparam int HCW = $clog2(ALLRED + 1);

  logic [3:0][2:0] lamp_in_s;
  logic [3:0][3:0] flags_s;
  logic [3:0]      any_flag_s;
  logic            conflict_s;
  logic [2:0]      basic_code_s;
  logic [2:0]      code_s;

  state_t          state_r;
  logic [3:0][2:0] lamp_out_r;
  logic            fault_r;
  logic [2:0]      fault_code_r;
  logic [FCW-1:0]  flash_cnt_r;
  logic [HCW-1:0]  hold_cnt_r;
  logic            first_mon_r;

  assign lamp_in_s = {in_S, in_MT, in_M2, in_M1};

  for (genvar i = 0; i < 4; i++) begin : g_trk
    approach_tracker #(.MIN_YEL(MIN_YEL)) u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .lamp     (lamp_in_s[i]),
      .suppress (first_mon_r),
      .flags    (flags_s[i])
    );
  end

  assign any_flag_s = flags_s[0] | flags_s[1] | flags_s[2] | flags_s[3];

  // S conflicts with every main approach; MT conflicts with M2
  assign conflict_s = ((in_S != RED) && ((in_M1 != RED) || (in_M2 != RED) || (in_MT != RED))) ||
                      ((in_MT != RED) && (in_M2 != RED));

  // Lowest-numbered failing check wins
  always_comb begin
    basic_code_s = FC_NONE;
    if (any_flag_s[0]) begin
      basic_code_s = FC_ONEHOT;
    end else if (conflict_s) begin
      basic_code_s = FC_CONFLICT;
    end else begin
      basic_code_s = FC_NONE;
    end
    code_s = basic_code_s;
    if (basic_code_s != FC_NONE) begin
      code_s = basic_code_s;
    end else if (any_flag_s[1]) begin
      code_s = FC_G2R;
    end else if (any_flag_s[2]) begin
      code_s = FC_SHORT_YEL;
    end else if (any_flag_s[3]) begin
      code_s = FC_BAD_SEQ;
    end else begin
      code_s = FC_NONE;
    end
  end

  // Monitor FSM with registered lamp drive, fault flag and cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_MON;
      lamp_out_r   <= {4{RED}};
      fault_r      <= 1'b0;
      fault_code_r <= FC_NONE;
      flash_cnt_r  <= {FCW{1'b0}};
      hold_cnt_r   <= {HCW{1'b0}};
      first_mon_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_MON: begin
          first_mon_r <= 1'b0;
          if (code_s != FC_NONE) begin
            state_r      <= ST_FLASH;
            lamp_out_r   <= {4{RED}};
            fault_r      <= 1'b1;
            fault_code_r <= code_s;
            flash_cnt_r  <= {FCW{1'b0}};
          end else begin
            lamp_out_r <= lamp_in_s;
          end
        end
        ST_FLASH: begin
          if (clr_fault) begin
            state_r    <= ST_RECOVER;
            lamp_out_r <= {4{RED}};
            hold_cnt_r <= {HCW{1'b0}};
          end else begin
            lamp_out_r  <= (flash_cnt_r < FCW'(FLASH_HALF)) ? {4{DARK}} : {4{RED}};
            flash_cnt_r <= (flash_cnt_r == FCW'(2 * FLASH_HALF - 1)) ?
                           {FCW{1'b0}} : flash_cnt_r + FCW'(1);
          end
        end
        ST_RECOVER: begin
          lamp_out_r <= {4{RED}};
          if (hold_cnt_r == HCW'(ALLRED - 1)) begin
            if (basic_code_s != FC_NONE) begin
              state_r      <= ST_FLASH;
              fault_code_r <= basic_code_s;
              flash_cnt_r  <= {FCW{1'b0}};
            end else begin
              state_r      <= ST_MON;
              fault_r      <= 1'b0;
              fault_code_r <= FC_NONE;
              first_mon_r  <= 1'b1;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HCW'(1);
          end
        end
        default: begin
          state_r      <= ST_MON;
          lamp_out_r   <= {4{RED}};
          fault_r      <= 1'b0;
          fault_code_r <= FC_NONE;
          flash_cnt_r  <= {FCW{1'b0}};
          hold_cnt_r   <= {HCW{1'b0}};
          first_mon_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_M1     = lamp_out_r[0];
  assign out_M2     = lamp_out_r[1];
  assign out_MT     = lamp_out_r[2];
  assign out_S      = lamp_out_r[3];
  assign fault      = fault_r;
  assign fault_code = fault_code_r;

endmodule

// File: tb/tb_light_safety_monitor.sv
// Scoreboard bench for light_safety_monitor: directed scenarios plus random
// request streams, checked against a cycle-level behavioural reference.
module tb_light_safety_monitor;
  import light_pkg::*;

  localparam int MIN_YEL    = 3;
  localparam int FLASH_HALF = 4;
  localparam int ALLRED     = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_M1, in_M2, in_MT, in_S;
  logic       clr_fault;
  logic [2:0] out_M1, out_M2, out_MT, out_S;
  logic       fault;
  logic [2:0] fault_code;

  always #5 clk = ~clk;

  light_safety_monitor #(.MIN_YEL(MIN_YEL), .FLASH_HALF(FLASH_HALF), .ALLRED(ALLRED)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_M1(in_M1), .in_M2(in_M2), .in_MT(in_MT), .in_S(in_S),
    .clr_fault(clr_fault),
    .out_M1(out_M1), .out_M2(out_M2), .out_MT(out_MT), .out_S(out_S),
    .fault(fault), .fault_code(fault_code)
  );

  typedef struct packed {
    logic [3:0][2:0] lamps;
    logic            flt;
    logic [2:0]      code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0 = monitoring, 1 = flashing, 2 = all-red recovery
  logic [2:0] m_prev[4];
  int         m_yrun[4];
  int         m_mode, m_k, m_r;
  logic [2:0] m_code;
  bit         m_first;
  logic [2:0] m_out[4];

  function automatic logic [2:0] ref_code(input logic [3:0][2:0] l, input bit basic_only);
    bit c1 = 0, c2 = 0, c3 = 0, c4 = 0, c5 = 0;
    for (int i = 0; i < 4; i++) begin
      if ($countones(l[i]) != 1) c1 = 1;
      if (!basic_only && !m_first) begin
        if (m_prev[i] == GREEN && l[i] == RED) c3 = 1;
        if (m_prev[i] == YELLOW && l[i] == RED && m_yrun[i] < MIN_YEL) c4 = 1;
        if ((m_prev[i] == RED && l[i] == YELLOW) || (m_prev[i] == YELLOW && l[i] == GREEN)) c5 = 1;
      end
    end
    if (l[3] != RED && (l[0] != RED || l[1] != RED || l[2] != RED)) c2 = 1;
    if (l[2] != RED && l[1] != RED) c2 = 1;
    if (c1) return 3'd1;
    if (c2) return 3'd2;
    if (c3) return 3'd3;
    if (c4) return 3'd4;
    if (c5) return 3'd5;
    return 3'd0;
  endfunction

  task automatic model_step(input logic [3:0][2:0] l, input bit clr, input bit rst);
    logic [2:0] c;
    exp_t e;
    if (!rst) begin
      m_mode = 0; m_k = 0; m_r = 0; m_code = 3'd0; m_first = 0;
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = RED; m_yrun[i] = 0; m_out[i] = RED;
      end
    end else begin
      case (m_mode)
        0: begin
          c = ref_code(l, 0);
          m_first = 0;
          if (c != 3'd0) begin
            m_mode = 1; m_code = c; m_k = 0;
            for (int i = 0; i < 4; i++) m_out[i] = RED;
          end else begin
            for (int i = 0; i < 4; i++) m_out[i] = l[i];
          end
        end
        1: begin
          if (clr) begin
            m_mode = 2; m_r = 0;
            for (int i = 0; i < 4; i++) m_out[i] = RED;
          end else begin
            m_k++;
            for (int i = 0; i < 4; i++) m_out[i] = (((m_k - 1) / FLASH_HALF) % 2 == 0) ? DARK : RED;
          end
        end
        default: begin
          m_r++;
          for (int i = 0; i < 4; i++) m_out[i] = RED;
          if (m_r == ALLRED) begin
            c = ref_code(l, 1);
            if (c != 3'd0) begin
              m_mode = 1; m_code = c; m_k = 0;
            end else begin
              m_mode = 0; m_code = 3'd0; m_first = 1;
            end
          end
        end
      endcase
      for (int i = 0; i < 4; i++) begin
        m_yrun[i] = (l[i] == YELLOW) ? ((m_yrun[i] < MIN_YEL) ? m_yrun[i] + 1 : MIN_YEL) : 0;
        m_prev[i] = l[i];
      end
    end
    for (int i = 0; i < 4; i++) e.lamps[i] = m_out[i];
    e.flt  = (m_mode != 0);
    e.code = m_code;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [2:0] m1, m2, mt, s, input bit clr, input bit rst);
    @(negedge clk);
    in_M1 = m1; in_M2 = m2; in_MT = mt; in_S = s;
    clr_fault = clr;
    rst_n = rst;
    model_step({s, mt, m2, m1}, clr, rst);
  endtask

  task automatic hold(input logic [2:0] m1, m2, mt, s, input int n);
    for (int i = 0; i < n; i++) step(m1, m2, mt, s, 1'b0, 1'b1);
  endtask

  task automatic expect_code(input logic [2:0] c, input string name);
    @(posedge clk);
    #2;
    n_checks++;
    if (fault_code !== c || fault !== (c != 3'd0)) begin
      n_fail++;
      $display("FAIL %s: fault_code=%0d fault=%b, required fault_code=%0d fault=%b",
               name, fault_code, fault, c, (c != 3'd0));
    end
  endtask

  task automatic legal_cycle();
    hold(GREEN, GREEN, RED, RED, 8);
    hold(GREEN, YELLOW, RED, RED, 3);
    hold(GREEN, RED, RED, RED, 1);
    hold(GREEN, RED, GREEN, RED, 6);
    hold(YELLOW, RED, YELLOW, RED, 3);
    hold(RED, RED, RED, RED, 1);
    hold(RED, RED, RED, GREEN, 5);
    hold(RED, RED, RED, YELLOW, 3);
    hold(RED, RED, RED, RED, 1);
  endtask

  // Scoreboard monitor: one expectation per clock, sampled just after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({out_S, out_MT, out_M2, out_M1} !== e.lamps || fault !== e.flt || fault_code !== e.code) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: lamps=%h fault=%b code=%0d, required lamps=%h fault=%b code=%0d",
                 $time, {out_S, out_MT, out_M2, out_M1}, fault, fault_code, e.lamps, e.flt, e.code);
      end
    end
  end

  initial begin
    logic [2:0] cur[4];
    rst_n = 1'b0; clr_fault = 1'b0;
    in_M1 = RED; in_M2 = RED; in_MT = RED; in_S = RED;
    for (int i = 0; i < 3; i++) step(RED, RED, RED, RED, 1'b0, 1'b0);

    legal_cycle();
    legal_cycle();

    // S green against M1 green, then watch the flash pattern
    step(GREEN, RED, RED, GREEN, 1'b0, 1'b1);
    expect_code(3'd2, "conflict_s_m1");
    hold(RED, RED, RED, RED, 10);
    step(RED, RED, RED, RED, 1'b1, 1'b1);
    hold(RED, RED, RED, RED, ALLRED + 1);
    expect_code(3'd0, "recover_to_mon");

    // Recovery attempted while the conflict persists
    step(GREEN, RED, RED, GREEN, 1'b0, 1'b1);
    hold(GREEN, RED, RED, GREEN, 3);
    step(GREEN, RED, RED, GREEN, 1'b1, 1'b1);
    hold(GREEN, RED, RED, GREEN, ALLRED + 1);
    expect_code(3'd2, "recover_conflict_refault");
    hold(RED, RED, RED, RED, 2);
    step(RED, RED, RED, RED, 1'b1, 1'b1);
    hold(RED, RED, RED, RED, ALLRED + 1);

    // Short yellow on M2
    hold(RED, GREEN, RED, RED, 4);
    hold(RED, YELLOW, RED, RED, 2);
    step(RED, RED, RED, RED, 1'b0, 1'b1);
    expect_code(3'd4, "short_yellow");

    // Recover holding M1 green; green->red is masked in the first MON cycle
    hold(GREEN, RED, RED, RED, 3);
    step(GREEN, RED, RED, RED, 1'b1, 1'b1);
    hold(GREEN, RED, RED, RED, ALLRED);
    step(RED, RED, RED, RED, 1'b0, 1'b1);
    expect_code(3'd0, "first_mon_suppress");
    hold(GREEN, RED, RED, RED, 3);
    step(RED, RED, RED, RED, 1'b0, 1'b1);
    expect_code(3'd3, "green_to_red");
    hold(RED, RED, RED, RED, 2);
    step(RED, RED, RED, RED, 1'b1, 1'b1);
    hold(RED, RED, RED, RED, ALLRED + 1);

    // Non-one-hot input outranks the simultaneous conflict
    step(GREEN, RED, 3'b011, GREEN, 1'b0, 1'b1);
    expect_code(3'd1, "onehot_priority");

    // Asynchronous reset in the middle of the flash
    hold(RED, RED, RED, RED, 5);
    step(RED, RED, RED, RED, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({out_S, out_MT, out_M2, out_M1} !== {4{RED}} || fault !== 1'b0 || fault_code !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: lamps=%h fault=%b code=%0d, required lamps=924 fault=0 code=0",
               {out_S, out_MT, out_M2, out_M1}, fault, fault_code);
    end
    step(RED, RED, RED, RED, 1'b0, 1'b0);
    hold(GREEN, GREEN, RED, RED, 4);
    legal_cycle();

    // Random request streams with occasional corruption, acks and resets
    for (int i = 0; i < 4; i++) cur[i] = RED;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(99);
        if (r >= 75 && r < 98) begin
          case ($urandom_range(2))
            0: cur[i] = GREEN;
            1: cur[i] = YELLOW;
            default: cur[i] = RED;
          endcase
        end else if (r >= 98) begin
          cur[i] = 3'($urandom_range(7));
        end
      end
      step(cur[0], cur[1], cur[2], cur[3], ($urandom_range(9) == 0), ($urandom_range(199) != 0));
    end

    hold(RED, RED, RED, RED, 2);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_safety_monitor.md
LIGHT_SAFETY_MONITOR -- requirements
Module: light_safety_monitor

Interface
REQ-001 SHALL have parameter MIN_YEL, default 3: minimum consecutive cycles an approach shows yellow.
REQ-002 SHALL have parameter FLASH_HALF, default 4: cycles per half-period of the fault red flash.
REQ-003 SHALL have parameter ALLRED, default 4: cycles of all-red hold during recovery.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_M1, in_M2, in_MT, in_S  input  3 each  light requests from the controller; one-hot encoding 001 green, 010 yellow, 100 red.
REQ-007 SHALL have port clr_fault  input  1  single-cycle fault acknowledge.
REQ-008 SHALL have ports out_M1, out_M2, out_MT, out_S  output  3 each  registered lamp drive, same encoding as the inputs.
REQ-009 SHALL have port fault  output  1  high while the state is FLASH or RECOVER.
REQ-010 SHALL have port fault_code  output  3  cause of the latched fault; 0 means none.

Function
REQ-011 SHALL implement states MON, FLASH and RECOVER.
REQ-012 In MON with all checks passing, each out_X SHALL take in_X on the next rising edge (1-cycle latency).
REQ-013 A check failure detected in MON SHALL, on the same edge, drive all outputs to 100, enter FLASH and latch fault_code, so an offending pattern never reaches the outputs.
REQ-014 Check: any input not one-hot -> code 1.
REQ-015 Check: S not red while any of M1, M2, MT is not red, or MT not red while M2 is not red -> code 2. M1/M2 and M1/MT are compatible pairs.
REQ-016 Check: green -> red transition on any approach -> code 3.
REQ-017 Check: yellow -> red after fewer than MIN_YEL consecutive yellow cycles -> code 4.
REQ-018 Check: red -> yellow or yellow -> green transition -> code 5.
REQ-019 Transition checks SHALL compare the current input with that approach's input from the previous cycle.
REQ-020 When several checks fail together, the lowest code SHALL win.
REQ-021 Each approach's yellow-run counter SHALL count consecutive yellow input cycles, saturate at MIN_YEL and clear on any non-yellow input.
REQ-022 Previous-input registers and yellow-run counters SHALL update every cycle in every state.
REQ-023 In FLASH, all outputs SHALL alternate between 100 and 000 every FLASH_HALF cycles, starting with 000 on the first FLASH cycle after entry.
REQ-024 fault_code SHALL hold its value throughout FLASH.
REQ-025 clr_fault in FLASH SHALL move to RECOVER on the next edge; clr_fault in MON or RECOVER SHALL be ignored.
REQ-026 In RECOVER, all outputs SHALL be 100 for ALLRED cycles.
REQ-027 At the end of the ALLRED hold, the block SHALL enter MON if the inputs pass codes 1 and 2, else return to FLASH with the new code.
REQ-028 On RECOVER -> MON, fault_code SHALL clear to 0.
REQ-029 Transition checks (codes 3-5) SHALL be suppressed during the first MON cycle after RECOVER.
REQ-030 A fault occurring on the same edge as a recovery exit SHALL take priority (FLASH).

Reset
REQ-031 While rst_n is low: state MON, all outputs 100, fault 0, fault_code 0, previous-input registers 100, yellow-run counters 0, flash and hold counters 0.
REQ-032 Reset assertion mid-FLASH or mid-RECOVER SHALL abort immediately to the reset values.
REQ-033 The first cycle after reset release SHALL be checked normally; red -> green is legal.

Structure
REQ-034 Shared package light_pkg SHALL hold the GREEN/YELLOW/RED encodings, the state encoding and the fault-code constants.
REQ-035 Sub-module approach_tracker SHALL be instantiated 4x, one per approach: previous-input register, yellow-run counter, per-approach codes 1/3/4/5 output.
REQ-036 The top level SHALL contain the conflict check, priority encode, FSM, and flash/hold counters.

Verification
REQ-037 Legal cycle M1/M2 green 8 cycles, M2 yellow 3, MT green, etc. -> outputs equal inputs delayed 1 cycle, fault never set.
REQ-038 in_S=001 while in_M1=001 -> next edge outputs all 100, fault=1, fault_code=2; then outputs 000 for 4 cycles, 100 for 4 cycles.
REQ-039 M2 yellow for 2 cycles then red -> fault_code=4; M1 green directly to red -> fault_code=3.
REQ-040 in_MT=011 together with an S/M1 conflict -> fault_code=1, proving priority.
REQ-041 clr_fault in FLASH with all-red inputs -> 4 cycles of all-100 outputs, then MON, fault=0, fault_code=0; repeat with conflict still present -> returns to FLASH with code 2.
REQ-042 rst_n pulsed low mid-FLASH -> outputs 100, fault 0 asynchronously; normal pass-through resumes after release.
